// File: rtl/nanci_pkg.sv
// Shared definitions for the Nanci sorting mesh.
//   state_t           : global sequencer state encoding
//   DIR_ROW / DIR_COL : value of the broadcast direction bit
//   ADDR_WIDTH / DATA_WIDTH : packet field widths used by the PE command decode
//   step_width / cyc_width / round_width : counter width helpers
package nanci_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ROW  = 3'd1,
        ST_COL  = 3'd2,
        ST_FROW = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic DIR_ROW = 1'b0;
    localparam logic DIR_COL = 1'b1;

    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 16;

    // A one-wide mesh still needs a 1-bit step counter.
    function automatic int step_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int cyc_width(input int sort_cycles);
        return $clog2(sort_cycles) + 1;
    endfunction

    function automatic int round_width(input int log_n);
        return $clog2(log_n) + 1;
    endfunction

endpackage

// File: rtl/nanci_step_timer.sv
// Step timer for one sort phase: cyc_cnt counts clocks inside a step,
// step_cnt counts transposition steps inside a phase.
//   clk, rst     : clock, asynchronous active-high reset
//   en           : advance the counters this cycle
//   clr          : restart from step 0 / cycle 0 (wins over en)
//   strobe_next  : counters will sit on the first cycle of a step after this edge
//   parity_next  : step parity the counters will hold after this edge
//   phase_end    : this cycle is the last cycle of the last step of the phase
module nanci_step_timer
    import nanci_pkg::*;
#(
    parameter int N           = 4,
    parameter int SORT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic strobe_next,
    output logic parity_next,
    output logic phase_end
);

    localparam int SW = step_width(N);
    localparam int CW = cyc_width(SORT_CYCLES);
    localparam logic [SW-1:0] STEP_LAST = SW'(N - 1);
    localparam logic [CW-1:0] CYC_LAST  = CW'(SORT_CYCLES - 1);

    logic [SW-1:0] step_cnt;
    logic [SW-1:0] step_next;
    logic [CW-1:0] cyc_cnt;
    logic [CW-1:0] cyc_next;
    logic          cyc_wrap;
    logic          step_wrap;

    assign cyc_wrap  = (cyc_cnt == CYC_LAST);
    assign step_wrap = (step_cnt == STEP_LAST);
    assign phase_end = en & cyc_wrap & step_wrap;

    // Both counters stop at their terminal values and return to zero
    // rather than running past them.
    always_comb begin
        cyc_next  = cyc_cnt;
        step_next = step_cnt;
        if (clr) begin
            cyc_next  = '0;
            step_next = '0;
        end else if (en) begin
            if (cyc_wrap) begin
                cyc_next  = '0;
                step_next = step_wrap ? '0 : step_cnt + 1'b1;
            end else begin
                cyc_next = cyc_cnt + 1'b1;
            end
        end
    end

    assign strobe_next = (cyc_next == '0);
    assign parity_next = step_next[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt  <= '0;
            step_cnt <= '0;
        end else begin
            cyc_cnt  <= cyc_next;
            step_cnt <= step_next;
        end
    end

endmodule

// File: rtl/nanci_sort_sequencer.sv
// Global shearsort phase sequencer for the Nanci N x N mesh.
// Runs LOG_N rounds of (row phase, column phase) followed by one final row
// phase; every phase is N odd-even transposition steps of SORT_CYCLES clocks.
//   clk, rst      : clock, asynchronous active-high reset
//   i_start       : start one full sort (only looked at in IDLE)
//   i_hold        : freeze the schedule while busy
//   o_busy        : a ROW/COL/FROW phase is running
//   o_done        : one-cycle pulse after the final step
//   o_cmd_valid   : strobe on the first cycle of each step
//   o_cmd_dir     : 0 row compare, 1 column compare
//   o_cmd_parity  : even (0) / odd (1) pairs for the current step
//   o_cmd_final   : final row phase in progress
// All outputs are registered from the next-state values, so i_start and
// i_hold act at the clock edge that samples them: a hold sampled at an edge
// freezes the following cycle and suppresses its strobe. A step's strobe is
// only ever issued on the edge that enters the step, so each step yields
// exactly one strobe no matter how long it is held.
module nanci_sort_sequencer
    import nanci_pkg::*;
#(
    parameter int N           = 4,
    parameter int LOG_N       = 2,
    parameter int SORT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_hold,
    output logic o_busy,
    output logic o_done,
    output logic o_cmd_valid,
    output logic o_cmd_dir,
    output logic o_cmd_parity,
    output logic o_cmd_final
);

    localparam int RW = round_width(LOG_N);

    state_t        state;
    state_t        state_next;
    logic [RW-1:0] round_cnt;
    logic [RW-1:0] round_next;

    logic busy_state;
    logic en;
    logic clr;
    logic strobe_next;
    logic parity_next;
    logic phase_end;

    logic busy_n;
    logic done_n;
    logic valid_n;
    logic dir_n;
    logic parity_n;
    logic final_n;

    assign busy_state = (state == ST_ROW) || (state == ST_COL) || (state == ST_FROW);
    assign en         = busy_state && !i_hold;
    // Counters restart on the start edge and on every phase change.
    assign clr        = ((state == ST_IDLE) && i_start) || phase_end;

    nanci_step_timer #(
        .N           (N),
        .SORT_CYCLES (SORT_CYCLES)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .clr         (clr),
        .strobe_next (strobe_next),
        .parity_next (parity_next),
        .phase_end   (phase_end)
    );

    always_comb begin
        state_next = state;
        round_next = round_cnt;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    state_next = ST_ROW;
                    round_next = '0;
                end
            end
            ST_ROW: begin
                if (phase_end) begin
                    state_next = (LOG_N == 0) ? ST_FROW : ST_COL;
                end
            end
            ST_COL: begin
                if (phase_end) begin
                    round_next = round_cnt + 1'b1;
                    state_next = (int'(round_cnt) == LOG_N - 1) ? ST_FROW : ST_ROW;
                end
            end
            ST_FROW: begin
                if (phase_end) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_n   = (state_next == ST_ROW) || (state_next == ST_COL) || (state_next == ST_FROW);
        done_n   = (state_next == ST_DONE);
        // A strobe needs the counters to actually move (or restart) onto cycle 0.
        valid_n  = busy_n && (clr || en) && strobe_next;
        dir_n    = (state_next == ST_COL) ? DIR_COL : DIR_ROW;
        parity_n = busy_n && parity_next;
        final_n  = (state_next == ST_FROW);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            round_cnt    <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_cmd_valid  <= 1'b0;
            o_cmd_dir    <= 1'b0;
            o_cmd_parity <= 1'b0;
            o_cmd_final  <= 1'b0;
        end else begin
            state        <= state_next;
            round_cnt    <= round_next;
            o_busy       <= busy_n;
            o_done       <= done_n;
            o_cmd_valid  <= valid_n;
            o_cmd_dir    <= dir_n;
            o_cmd_parity <= parity_n;
            o_cmd_final  <= final_n;
        end
    end

endmodule
